// File: rtl/copro09_mem_pkg.sv
// Shared types and constants for the coprocessor SRAM path.
// State encoding, port ids and default bus widths.
package copro09_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  localparam logic PORT_HOST = 1'b0;
  localparam logic PORT_CPU  = 1'b1;

  localparam int SRAM_ADDR_W = 19;
  localparam int SRAM_DATA_W = 8;
  localparam int BURST_W     = 4;

endpackage

// File: rtl/sram_arbiter_select.sv
// Combinational winner choice between host and cpu requests.
// SRAM_ARB_RR_EN selects strict round-robin instead of host-priority.
module arb_select
  import copro09_mem_pkg::*;
#(
  parameter int HOST_BURST_MAX = 4
) (
  input  logic               host_req,
  input  logic               cpu_req,
  input  logic               owner,
  input  logic [BURST_W-1:0] burst,
  output logic               grant,
  output logic               winner
);

  logic tie_win;

`ifdef SRAM_ARB_RR_EN
  logic unused_burst;
  assign unused_burst = ^burst;
  assign tie_win = ~owner;
`else
  logic unused_owner;
  assign unused_owner = owner;
  assign tie_win =
    (burst == BURST_W'(HOST_BURST_MAX)) ? PORT_CPU : PORT_HOST;
`endif

  // pick the port to serve this IDLE cycle
  always_comb begin
    grant  = host_req | cpu_req;
    winner = PORT_HOST;
    unique case (1'b1)
      host_req && cpu_req:  winner = tie_win;
      cpu_req && !host_req: winner = PORT_CPU;
      default:              winner = PORT_HOST;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter: host (C64 side) and 6809 cpu side.
// Build option SRAM_ARB_RR_EN: round-robin ties, no burst limit.
module sram_arbiter
  import copro09_mem_pkg::*;
#(
  parameter int ADDR_W         = SRAM_ADDR_W,
  parameter int DATA_W         = SRAM_DATA_W,
  parameter int WAIT_STATES    = 0,
  parameter int HOST_BURST_MAX = 4
) (
  input  logic              clock,
  input  logic              _reset,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] address_mem,
  input  logic [DATA_W-1:0] data_mem_in,
  output logic [DATA_W-1:0] data_mem_out,
  output logic              data_mem_oe,
  output logic              _we_mem,
  output logic              _ce_ram,
  output logic              owner
);

  state_t state, state_nx;
  logic [2:0] wcnt, wcnt_nx;
  logic lat_we, lat_we_nx;
  logic grant, winner;
  logic [BURST_W-1:0] burst;

  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] dout_nx;
  logic [DATA_W-1:0] hrd_nx, crd_nx;
  logic oe_nx, we_n_nx, ce_n_nx;
  logic hack_nx, cack_nx, owner_nx;

`ifndef SRAM_ARB_RR_EN
  logic [BURST_W-1:0] burst_nx;
`else
  assign burst = '0;
`endif

  arb_select #(
    .HOST_BURST_MAX(HOST_BURST_MAX)
  ) u_sel (
    .host_req(host_req),
    .cpu_req (cpu_req),
    .owner   (owner),
    .burst   (burst),
    .grant   (grant),
    .winner  (winner)
  );

  // next state and next registered pin/port values
  always_comb begin
    state_nx  = state;
    wcnt_nx   = wcnt;
    lat_we_nx = lat_we;
    owner_nx  = owner;
    addr_nx   = address_mem;
    dout_nx   = data_mem_out;
    oe_nx     = data_mem_oe;
    ce_n_nx   = _ce_ram;
    we_n_nx   = 1'b1;
    hack_nx   = 1'b0;
    cack_nx   = 1'b0;
    hrd_nx    = host_rdata;
    crd_nx    = cpu_rdata;
`ifndef SRAM_ARB_RR_EN
    burst_nx  = burst;
`endif
    unique case (state)
      IDLE: begin
        ce_n_nx = 1'b1;
        oe_nx   = 1'b0;
        if (grant) begin
          state_nx = SETUP;
          owner_nx = winner;
          ce_n_nx  = 1'b0;
          if (winner == PORT_CPU) begin
            addr_nx   = cpu_addr;
            lat_we_nx = cpu_we;
            oe_nx     = cpu_we;
            if (cpu_we) dout_nx = cpu_wdata;
          end else begin
            addr_nx   = host_addr;
            lat_we_nx = host_we;
            oe_nx     = host_we;
            if (host_we) dout_nx = host_wdata;
          end
`ifndef SRAM_ARB_RR_EN
          if (winner == PORT_CPU || !cpu_req)
            burst_nx = '0;
          else if (burst != BURST_W'(HOST_BURST_MAX))
            burst_nx = burst + 1'b1;
`endif
        end
      end
      SETUP: begin
        state_nx = ACCESS;
        wcnt_nx  = '0;
        we_n_nx  = ~lat_we;
      end
      ACCESS: begin
        if (wcnt == 3'(WAIT_STATES)) begin
          state_nx = DONE;
          if (owner == PORT_CPU) begin
            cack_nx = 1'b1;
            if (!lat_we) crd_nx = data_mem_in;
          end else begin
            hack_nx = 1'b1;
            if (!lat_we) hrd_nx = data_mem_in;
          end
        end else begin
          wcnt_nx = wcnt + 3'd1;
          we_n_nx = ~lat_we;
        end
      end
      DONE: begin
        state_nx = IDLE;
        ce_n_nx  = 1'b1;
        oe_nx    = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state and output registers; reset drops any access in flight
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state        <= IDLE;
      wcnt         <= '0;
      lat_we       <= 1'b0;
      owner        <= PORT_HOST;
      address_mem  <= '0;
      data_mem_out <= '0;
      data_mem_oe  <= 1'b0;
      _we_mem      <= 1'b1;
      _ce_ram      <= 1'b1;
      host_ack     <= 1'b0;
      cpu_ack      <= 1'b0;
      host_rdata   <= '0;
      cpu_rdata    <= '0;
`ifndef SRAM_ARB_RR_EN
      burst        <= '0;
`endif
    end else begin
      state        <= state_nx;
      wcnt         <= wcnt_nx;
      lat_we       <= lat_we_nx;
      owner        <= owner_nx;
      address_mem  <= addr_nx;
      data_mem_out <= dout_nx;
      data_mem_oe  <= oe_nx;
      _we_mem      <= we_n_nx;
      _ce_ram      <= ce_n_nx;
      host_ack     <= hack_nx;
      cpu_ack      <= cack_nx;
      host_rdata   <= hrd_nx;
      cpu_rdata    <= crd_nx;
`ifndef SRAM_ARB_RR_EN
      burst        <= burst_nx;
`endif
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: WAIT_STATES=0 and WAIT_STATES=2 instances.
// Directed vectors plus reset, held-request and arbitration sequences.
module tb_sram_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic rst_n;

  logic h_req, h_we, h_ack, c_req, c_we, c_ack;
  logic [AW-1:0] h_addr, c_addr, m_addr;
  logic [DW-1:0] h_wdata, h_rdata, c_wdata, c_rdata;
  logic [DW-1:0] m_in, m_out;
  logic m_oe, m_we_n, m_ce_n, own;

  logic h2_req, h2_we, h2_ack, c2_req, c2_we, c2_ack;
  logic [AW-1:0] h2_addr, c2_addr, m2_addr;
  logic [DW-1:0] h2_wdata, h2_rdata, c2_wdata, c2_rdata;
  logic [DW-1:0] m2_in, m2_out;
  logic m2_oe, m2_we_n, m2_ce_n, own2;

  sram_arbiter #(.WAIT_STATES(0), .HOST_BURST_MAX(4)) u0 (
    .clock(clock), ._reset(rst_n),
    .host_req(h_req), .host_we(h_we), .host_addr(h_addr),
    .host_wdata(h_wdata), .host_ack(h_ack), .host_rdata(h_rdata),
    .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr),
    .cpu_wdata(c_wdata), .cpu_ack(c_ack), .cpu_rdata(c_rdata),
    .address_mem(m_addr), .data_mem_in(m_in), .data_mem_out(m_out),
    .data_mem_oe(m_oe), ._we_mem(m_we_n), ._ce_ram(m_ce_n),
    .owner(own)
  );

  sram_arbiter #(.WAIT_STATES(2), .HOST_BURST_MAX(4)) u2 (
    .clock(clock), ._reset(rst_n),
    .host_req(h2_req), .host_we(h2_we), .host_addr(h2_addr),
    .host_wdata(h2_wdata), .host_ack(h2_ack), .host_rdata(h2_rdata),
    .cpu_req(c2_req), .cpu_we(c2_we), .cpu_addr(c2_addr),
    .cpu_wdata(c2_wdata), .cpu_ack(c2_ack), .cpu_rdata(c2_rdata),
    .address_mem(m2_addr), .data_mem_in(m2_in), .data_mem_out(m2_out),
    .data_mem_oe(m2_oe), ._we_mem(m2_we_n), ._ce_ram(m2_ce_n),
    .owner(own2)
  );

  // SRAM models: byte i preloaded with i[7:0]^A5, written at end of _we pulse
  logic [7:0] mem0 [0:4095];
  logic [7:0] mem2 [0:4095];
  assign m_in  = mem0[m_addr[11:0]];
  assign m2_in = mem2[m2_addr[11:0]];

  initial begin
    for (int i = 0; i < 4096; i++) mem0[i] = 8'(i) ^ 8'hA5;
    forever begin
      @(posedge m_we_n);
      if (m_ce_n === 1'b0 && m_oe === 1'b1) mem0[m_addr[11:0]] = m_out;
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem2[i] = 8'(i) ^ 8'hA5;
    forever begin
      @(posedge m2_we_n);
      if (m2_ce_n === 1'b0 && m2_oe === 1'b1) mem2[m2_addr[11:0]] = m2_out;
    end
  end

  int nh = 0;
  always @(negedge clock) if (h_ack === 1'b1) nh = nh + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_acc(input bit inst, input bit port, input bit we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        output int lat, output int welow, output bit aok);
    logic ack;
    @(negedge clock);
    if (inst) begin
      if (port) begin
        c2_req = 1; c2_we = we; c2_addr = addr; c2_wdata = wd;
      end else begin
        h2_req = 1; h2_we = we; h2_addr = addr; h2_wdata = wd;
      end
    end else begin
      if (port) begin
        c_req = 1; c_we = we; c_addr = addr; c_wdata = wd;
      end else begin
        h_req = 1; h_we = we; h_addr = addr; h_wdata = wd;
      end
    end
    lat = 0; welow = 0; aok = 1; ack = 0;
    while (!ack && lat < 20) begin
      @(negedge clock);
      lat++;
      if ((inst ? m2_we_n : m_we_n) == 1'b0) welow++;
      if ((inst ? m2_addr : m_addr) != addr) aok = 0;
      if ((inst ? m2_ce_n : m_ce_n) != 1'b0) aok = 0;
      ack = inst ? (port ? c2_ack : h2_ack) : (port ? c_ack : h_ack);
    end
    h_req = 0; c_req = 0; h2_req = 0; c2_req = 0;
  endtask

  typedef struct {
    bit port; bit we;
    logic [AW-1:0] addr; logic [DW-1:0] wdata;
    logic [DW-1:0] exp_h; logic [DW-1:0] exp_c;
  } vec_t;

  vec_t vt [9];
  bit exp_ord [10];
  logic [DW-1:0] exp5 [3];

  initial begin
    int lat, welow, n, cyc;
    bit aok;

    vt[0] = '{0, 1, 19'h005A1, 8'h3C, 8'h00, 8'h00};
    vt[1] = '{0, 0, 19'h005A1, 8'h00, 8'h3C, 8'h00};
    vt[2] = '{1, 1, 19'h00010, 8'h77, 8'h3C, 8'h00};
    vt[3] = '{1, 0, 19'h00010, 8'h00, 8'h3C, 8'h77};
    vt[4] = '{0, 0, 19'h00020, 8'h00, 8'h85, 8'h77};
    vt[5] = '{1, 0, 19'h000FF, 8'h00, 8'h85, 8'h5A};
    vt[6] = '{0, 0, 19'h00010, 8'h00, 8'h77, 8'h5A};
    vt[7] = '{1, 1, 19'h005A1, 8'h99, 8'h77, 8'h5A};
    vt[8] = '{0, 0, 19'h005A1, 8'h00, 8'h99, 8'h5A};
`ifdef SRAM_ARB_RR_EN
    exp_ord = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`else
    exp_ord = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
    exp5 = '{8'hA5, 8'hA4, 8'hA7};

    rst_n = 0;
    h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    h2_req = 0; h2_we = 0; h2_addr = '0; h2_wdata = '0;
    c2_req = 0; c2_we = 0; c2_addr = '0; c2_wdata = '0;
    repeat (3) @(negedge clock);
    check("rst ce", m_ce_n, 1);
    check("rst we", m_we_n, 1);
    check("rst oe", m_oe, 0);
    check("rst addr", m_addr, 0);
    check("rst dout", m_out, 0);
    check("rst acks", {h_ack, c_ack}, 0);
    check("rst rdata", {h_rdata, c_rdata}, 0);
    check("rst owner", own, 0);
    rst_n = 1;

    // reset during the write pulse
    @(negedge clock);
    h_req = 1; h_we = 1; h_addr = 19'h007FF; h_wdata = 8'hEE;
    repeat (2) @(negedge clock);
    check("midwr we low", m_we_n, 0);
    #1 rst_n = 0;
    #1;
    check("async we", m_we_n, 1);
    check("async ce", m_ce_n, 1);
    check("async oe", m_oe, 0);
    h_req = 0;
    repeat (2) @(negedge clock);
    rst_n = 1;
    repeat (6) @(negedge clock);
    check("midwr no ack", nh, 0);
    check("midwr rdata", h_rdata, 0);

    // single-port vector table on the zero-wait instance
    for (int i = 0; i < 9; i++) begin
      do_acc(0, vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata,
             lat, welow, aok);
      check($sformatf("v%0d latency", i), lat, 3);
      check($sformatf("v%0d owner", i), own, int'(vt[i].port));
      check($sformatf("v%0d host_rdata", i), h_rdata, vt[i].exp_h);
      check($sformatf("v%0d cpu_rdata", i), c_rdata, vt[i].exp_c);
      if (vt[i].we) begin
        check($sformatf("v%0d we pulse", i), welow, 1);
        check($sformatf("v%0d addr held", i), aok, 1);
      end
    end

    // request held across three accesses
    @(negedge clock);
    h_req = 1; h_we = 0; h_addr = 19'h00100;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (h_ack) begin
        check($sformatf("held ack%0d cycle", n), cyc, 3 + 4 * n);
        check($sformatf("held ack%0d rdata", n), h_rdata, exp5[n]);
        n++;
        h_addr = 19'h00100 + 19'(n);
      end
    end
    h_req = 0;
    check("held ack count", n, 3);

    // two wait states on the second instance
    do_acc(1, 0, 0, 19'h00040, 8'h00, lat, welow, aok);
    check("ws2 host lat", lat, 5);
    check("ws2 host rdata", h2_rdata, 8'hE5);
    do_acc(1, 1, 0, 19'h00123, 8'h00, lat, welow, aok);
    check("ws2 cpu lat", lat, 5);
    check("ws2 cpu rdata", c2_rdata, 8'h86);
    check("ws2 host kept", h2_rdata, 8'hE5);
    check("ws2 addr held", aok, 1);

    // both ports requesting continuously from reset
    @(negedge clock);
    rst_n = 0;
    @(negedge clock);
    rst_n = 1;
    h_req = 1; h_we = 0; h_addr = 19'h00200;
    c_req = 1; c_we = 0; c_addr = 19'h00300;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (h_ack || c_ack) begin
        check($sformatf("grant%0d port", n), c_ack, int'(exp_ord[n]));
        check($sformatf("grant%0d owner", n), own, int'(exp_ord[n]));
        n++;
      end
    end
    h_req = 0; c_req = 0;
    check("grant count", n, 10);
    check("tie cpu rdata", c_rdata, 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
